tt_timer_core: RTL and testbench

//   Parametrised programmable timer/counter, successor to the free-running 8-bit counter.

---
 rtl/tt_timer_core.sv | 125 ++++++++++++
 tb/tb_tt_timer_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tt_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tt_timer_core
// Purpose  : Programmable timer/counter with prescaler, start/stop control,
//            four counting modes and a one-cycle expire pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tt_timer_core #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   reload,
    input  logic               start,
    input  logic               stop,
    output logic [WIDTH-1:0]   count,
    output logic               running,
    output logic               done,
    output logic               expire
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_FREE_UP   = 2'b00;
    localparam logic [1:0] c_MODE_PERIODIC  = 2'b01;
    localparam logic [1:0] c_MODE_ONE_SHOT  = 2'b10;
    localparam logic [1:0] c_MODE_UP_RELOAD = 2'b11;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic               r_expire;
    logic               w_expire_nxt;
    logic               w_tick;

    // '>=' rather than '==' so a prescale lowered mid-run cannot strand the divider.
    assign w_tick = (r_state == S_RUN) && (r_presc >= prescale);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_presc_nxt  = r_presc;
        w_expire_nxt = 1'b0;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
        end else if (start) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
            // Down-counting modes load reload; up-counting modes begin at zero.
            w_count_nxt = (mode[0] ^ mode[1]) ? reload : '0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                w_presc_nxt = '0;
                case (mode)
                    c_MODE_FREE_UP: begin
                        w_count_nxt  = r_count + 1'b1;
                        w_expire_nxt = &r_count;
                    end
                    c_MODE_PERIODIC: begin
                        if (r_count == '0) begin
                            w_count_nxt  = reload;
                            w_expire_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                        end
                    end
                    c_MODE_ONE_SHOT: begin
                        if (r_count == '0) begin
                            w_expire_nxt = 1'b1;
                            w_state_nxt  = S_DONE;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                        end
                    end
                    c_MODE_UP_RELOAD: begin
                        if (r_count >= reload) begin
                            w_count_nxt  = '0;
                            w_expire_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                    default: begin
                        w_count_nxt = r_count;
                    end
                endcase
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_presc  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_presc  <= w_presc_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    assign count   = r_count;
    assign running = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign expire  = r_expire;

endmodule
`default_nettype wire

// File: tb/tb_tt_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_timer_core
// Purpose  : Scoreboard bench for tt_timer_core with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_timer_core;

    logic       clk;
    logic       rst;
    logic [3:0] prescale;
    logic [1:0] mode;
    logic [7:0] reload;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       expire;

    typedef struct {
        logic [7:0] cnt;
        logic       run;
        logic       dn;
        logic       ex;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    tt_timer_core #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .mode     (mode),
        .reload   (reload),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .running  (running),
        .done     (done),
        .expire   (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of control inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic st, input logic sp,
                        input logic [7:0] c, input logic ru, input logic dn,
                        input logic ex, input string nm);
        exp_t e;
        @(negedge clk);
        rst   = r;
        start = st;
        stop  = sp;
        e.cnt = c;
        e.run = ru;
        e.dn  = dn;
        e.ex  = ex;
        e.tag = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new registered output every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (count !== e.cnt || running !== e.run || done !== e.dn || expire !== e.ex) begin
                    bad++;
                    $display("FAIL %s: got count=%0d running=%b done=%b expire=%b, want count=%0d running=%b done=%b expire=%b",
                             e.tag, count, running, done, expire, e.cnt, e.run, e.dn, e.ex);
                end
            end
        end
    end

    initial begin
        logic [7:0] seq3 [16];
        logic       ex3  [16];
        logic [7:0] v;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        prescale = 4'd0; mode = 2'b00; reload = 8'd0;

        // 1. reset dominates start/stop
        step(1, 1, 0, 8'd0, 0, 0, 0, "rst_start");
        step(1, 0, 1, 8'd0, 0, 0, 0, "rst_stop");
        step(0, 0, 0, 8'd0, 0, 0, 0, "idle_hold");

        // 2. free-up, prescale 0, full wrap
        mode = 2'b00; prescale = 4'd0;
        step(0, 1, 0, 8'd0, 1, 0, 0, "m00_start");
        for (int i = 1; i < 256; i++) begin
            v = i[7:0];
            step(0, 0, 0, v, 1, 0, 0, "m00_count");
        end
        step(0, 0, 0, 8'd0, 1, 0, 1, "m00_wrap");
        step(0, 0, 0, 8'd1, 1, 0, 0, "m00_after_wrap");
        step(0, 0, 1, 8'd1, 0, 0, 0, "m00_stop");

        // 3. periodic-down, reload 3, prescale 1: period of 8 clocks
        mode = 2'b01; prescale = 4'd1; reload = 8'd3;
        step(0, 1, 0, 8'd3, 1, 0, 0, "m01_start");
        seq3 = '{8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd3,
                 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd3};
        ex3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, seq3[i], 1, 0, ex3[i], "m01_seq");
        end
        step(0, 0, 1, 8'd3, 0, 0, 0, "m01_stop");

        // 4. one-shot, reload 2, prescale 0
        mode = 2'b10; prescale = 4'd0; reload = 8'd2;
        step(0, 1, 0, 8'd2, 1, 0, 0, "m10_start");
        step(0, 0, 0, 8'd1, 1, 0, 0, "m10_dec1");
        step(0, 0, 0, 8'd0, 1, 0, 0, "m10_dec0");
        step(0, 0, 0, 8'd0, 0, 1, 1, "m10_expire");
        reload = 8'd9;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 8'd0, 0, 1, 0, "m10_done_hold");
        end
        step(0, 0, 1, 8'd0, 0, 0, 0, "m10_stop");

        // 5. up-to-reload wrap, restart while running, then start+stop together
        mode = 2'b11; prescale = 4'd0; reload = 8'd5;
        step(0, 1, 0, 8'd0, 1, 0, 0, "m11_start");
        for (int i = 1; i <= 5; i++) begin
            v = i[7:0];
            step(0, 0, 0, v, 1, 0, 0, "m11_count");
        end
        step(0, 0, 0, 8'd0, 1, 0, 1, "m11_wrap");
        step(0, 0, 0, 8'd1, 1, 0, 0, "m11_after_wrap");
        step(0, 1, 0, 8'd0, 1, 0, 0, "m11_restart");
        step(0, 0, 0, 8'd1, 1, 0, 0, "m11_c1");
        step(0, 0, 0, 8'd2, 1, 0, 0, "m11_c2");
        step(0, 0, 0, 8'd3, 1, 0, 0, "m11_c3");
        step(0, 1, 1, 8'd3, 0, 0, 0, "m11_start_stop");
        step(0, 0, 0, 8'd3, 0, 0, 0, "m11_idle_hold1");
        step(0, 0, 0, 8'd3, 0, 0, 0, "m11_idle_hold2");

        // 6a. periodic-down, reset pulse at count 7
        mode = 2'b01; prescale = 4'd0; reload = 8'd9;
        step(0, 1, 0, 8'd9, 1, 0, 0, "m01b_start");
        step(0, 0, 0, 8'd8, 1, 0, 0, "m01b_c8");
        step(0, 0, 0, 8'd7, 1, 0, 0, "m01b_c7");
        step(1, 0, 0, 8'd0, 0, 0, 0, "m01b_rst");
        step(0, 0, 0, 8'd0, 0, 0, 0, "m01b_post_rst");

        // 6b. prescale 2, restart at count 2 mid-prescale: divider must restart from zero
        prescale = 4'd2; reload = 8'd4;
        step(0, 1, 0, 8'd4, 1, 0, 0, "m01c_start");
        step(0, 0, 0, 8'd4, 1, 0, 0, "m01c_p1");
        step(0, 0, 0, 8'd4, 1, 0, 0, "m01c_p2");
        step(0, 0, 0, 8'd3, 1, 0, 0, "m01c_c3");
        step(0, 0, 0, 8'd3, 1, 0, 0, "m01c_c3b");
        step(0, 0, 0, 8'd3, 1, 0, 0, "m01c_c3c");
        step(0, 0, 0, 8'd2, 1, 0, 0, "m01c_c2");
        step(0, 0, 0, 8'd2, 1, 0, 0, "m01c_c2b");
        reload = 8'd6;
        step(0, 1, 0, 8'd6, 1, 0, 0, "m01c_restart");
        step(0, 0, 0, 8'd6, 1, 0, 0, "m01c_r_p1");
        step(0, 0, 0, 8'd6, 1, 0, 0, "m01c_r_p2");
        step(0, 0, 0, 8'd5, 1, 0, 0, "m01c_r_c5");

        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
